// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types and constants for the SPI master.
//   master_state_e : FSM state encoding
//   CMD_*          : opcode values carried in cmd_word[9:8]
//   DEF_*          : default frame timing, in SS_n-low clock cycles
package spi_master_pkg;

  typedef enum logic [2:0] {
    M_IDLE,
    M_CMD,
    M_SHIFT,
    M_HOLD,
    M_READ,
    M_GAP
  } master_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int unsigned CMD_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 5;

  localparam int unsigned DEF_FRAME_SHORT = 13;
  localparam int unsigned DEF_FRAME_LONG  = 23;
  localparam int unsigned DEF_MISO_START  = 13;

  // Only read-data commands extend the frame to collect a byte.
  function automatic logic is_read_data(input logic [CMD_W-1:0] word);
    return word[CMD_W-1 -: 2] == CMD_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: command handshake, response and SPI pin bundle.
//   master modport : view of spi_master (drives SS_n/MOSI/cmd_ready/rsp/busy)
//   slave modport  : view of the host/bench side (drives cmd_valid/cmd_word/MISO)
interface spi_master_if;
  logic       cmd_valid;
  logic [9:0] cmd_word;
  logic       cmd_ready;
  logic       MISO;
  logic       SS_n;
  logic       MOSI;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_word, MISO,
    output cmd_ready, SS_n, MOSI, rsp_valid, rsp_data, busy
  );

  modport slave (
    output cmd_valid, cmd_word, MISO,
    input  cmd_ready, SS_n, MOSI, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_master_shifter.sv
// spi_master_shifter: datapath registers of the SPI master.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : load word_i into the transmit register, clear receive register
//   word_i     : command word to serialise
//   shift_i    : shift transmit register left by one
//   cap_i      : shift miso_i into the receive register (MSB first)
//   miso_i     : serial input bit
//   msb_o      : current transmit MSB
//   byte_o     : receive register contents
module spi_master_shifter
  import spi_master_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [CMD_W-1:0]  word_i,
  input  logic              shift_i,
  input  logic              cap_i,
  input  logic              miso_i,
  output logic              msb_o,
  output logic [DATA_W-1:0] byte_o
);

  logic [CMD_W-1:0]  tx_q;
  logic [DATA_W-1:0] rx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load_i) begin
        tx_q <= word_i;
      end else if (shift_i) begin
        tx_q <= {tx_q[CMD_W-2:0], 1'b0};
      end

      if (load_i) begin
        rx_q <= '0;
      end else if (cap_i) begin
        rx_q <= {rx_q[DATA_W-2:0], miso_i};
      end
    end
  end

  assign msb_o  = tx_q[CMD_W-1];
  assign byte_o = rx_q;

endmodule

// File: rtl/spi_master.sv
// spi_master: host-side SPI master for the team's SPI slave.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : spi_master_if.master
//           cmd_valid/cmd_word/cmd_ready : command handshake (10-bit word)
//           SS_n/MOSI/MISO               : SPI pins
//           rsp_valid/rsp_data           : read-data response pulse and byte
//           busy                         : acceptance through end of GAP
// Frame: cycle 0 repeats cmd_word[9] (slave state select), cycles 1..10 carry
// bits 9..0, then MOSI idles low until the frame length is reached.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned FRAME_SHORT = DEF_FRAME_SHORT,
  parameter int unsigned FRAME_LONG  = DEF_FRAME_LONG,
  parameter int unsigned MISO_START  = DEF_MISO_START
) (
  input  logic clk,
  input  logic rst_n,
  spi_master_if.master bus
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(FRAME_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(FRAME_LONG - 1);
  localparam logic [CNT_W-1:0] RD_ENTRY   = CNT_W'(MISO_START - 1);
  localparam logic [CNT_W-1:0] CAP_FIRST  = CNT_W'(MISO_START);
  localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(MISO_START + DATA_W - 1);

  master_state_e     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_rd_q;
  logic              ss_n_q;
  logic              mosi_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              busy_q;

  logic              cmd_ready;
  logic              accept;
  logic              shift_en;
  logic              cap_en;
  logic              tx_msb;
  logic [DATA_W-1:0] rx_byte;

  assign cmd_ready = (state_q == M_IDLE) && rst_n;
  assign accept    = bus.cmd_valid && cmd_ready;

  // MOSI is registered, so the transmit register is shifted on the same edge
  // that copies its MSB out; CMD already uses bit 9, SHIFT consumes bits 9..0.
  always_comb begin
    shift_en = 1'b0;
    cap_en   = 1'b0;
    if (state_q == M_CMD) begin
      shift_en = 1'b1;
    end else if (state_q == M_SHIFT && cnt_q != SHIFT_LAST) begin
      shift_en = 1'b1;
    end
    if (state_q == M_READ && cnt_q >= CAP_FIRST && cnt_q <= CAP_LAST) begin
      cap_en = 1'b1;
    end
  end

  spi_master_shifter u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .word_i  (bus.cmd_word),
    .shift_i (shift_en),
    .cap_i   (cap_en),
    .miso_i  (bus.MISO),
    .msb_o   (tx_msb),
    .byte_o  (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= M_IDLE;
      cnt_q       <= '0;
      is_rd_q     <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        M_IDLE: begin
          if (accept) begin
            state_q <= M_CMD;
            cnt_q   <= '0;
            is_rd_q <= is_read_data(bus.cmd_word);
            ss_n_q  <= 1'b0;
            mosi_q  <= bus.cmd_word[CMD_W-1];
            busy_q  <= 1'b1;
          end
        end
        M_CMD: begin
          state_q <= M_SHIFT;
          cnt_q   <= cnt_q + 1'b1;
          mosi_q  <= tx_msb;
        end
        M_SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHIFT_LAST) begin
            state_q <= M_HOLD;
            mosi_q  <= 1'b0;
          end else begin
            mosi_q  <= tx_msb;
          end
        end
        M_HOLD: begin
          if (!is_rd_q && cnt_q == SHORT_LAST) begin
            state_q <= M_GAP;
            ss_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (is_rd_q && cnt_q == RD_ENTRY) begin
              state_q <= M_READ;
            end
          end
        end
        M_READ: begin
          if (cnt_q == LONG_LAST) begin
            state_q     <= M_GAP;
            ss_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rx_byte;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        M_GAP: begin
          state_q <= M_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= M_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master. Stimulus pushes the
// expected frame (length, MOSI cycles 0..10, response) when a command is
// issued; a negedge monitor rebuilds each SS_n-low frame and pops/compares
// at the GAP cycle. A separate driver plays MISO by frame cycle index.
module tb_spi_master;

  typedef struct {
    string       name;
    int unsigned len;
    logic [10:0] mosi;
    bit          has_rsp;
    logic [7:0]  rsp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_if bus ();

  spi_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input string name, input int unsigned len,
                              input logic [10:0] mosi, input bit has_rsp,
                              input logic [7:0] rsp);
    exp_t e;
    e.name = name; e.len = len; e.mosi = mosi; e.has_rsp = has_rsp; e.rsp = rsp;
    return e;
  endfunction

  // MISO driver: frame cycle k (0-based) gets miso_pat[7-(k-13)] for k=13..20.
  logic [7:0]  miso_pat  = 8'h00;
  logic        miso_idle = 1'b0;
  logic        miso_r    = 1'b0;
  int unsigned d_k       = 0;
  assign bus.MISO = miso_r;

  always @(negedge clk) begin
    if (bus.SS_n === 1'b0) begin
      if (d_k >= 13 && d_k <= 20) begin
        int idx;
        idx = 20 - int'(d_k);
        miso_r = miso_pat[idx];
      end else begin
        miso_r = miso_idle;
      end
      d_k++;
    end else begin
      d_k    = 0;
      miso_r = miso_idle;
    end
  end

  // Monitor / scoreboard checker.
  bit          mon_en       = 1'b0;
  bit          prev_ss      = 1'b1;
  bit          rsp_spurious = 1'b0;
  bit          m_trail_bad  = 1'b0;
  int unsigned m_len        = 0;
  int unsigned m_hi         = 100;
  logic [10:0] m_mosi       = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.SS_n === 1'b0) begin
        if (prev_ss) begin
          check("gap_ge2", 32'(m_hi >= 2), 32'd1);
          m_len       = 0;
          m_mosi      = '0;
          m_trail_bad = 1'b0;
        end
        if (m_len < 11) m_mosi[10 - m_len] = bus.MOSI;
        else if (bus.MOSI !== 1'b0) m_trail_bad = 1'b1;
        if (bus.rsp_valid !== 1'b0) rsp_spurious = 1'b1;
        m_len++;
        prev_ss = 1'b0;
      end else begin
        if (!prev_ss) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got frame of %0d cycles, expected none", m_len);
          end else begin
            exp_t        e;
            logic [10:0] mask;
            e    = sb_q.pop_front();
            mask = 11'h7FF;
            if (e.len < 11) mask = ~(11'h7FF >> e.len);
            check({e.name, "_len"}, m_len, e.len);
            check({e.name, "_mosi"}, 32'(m_mosi & mask), 32'(e.mosi & mask));
            check({e.name, "_mosi_tail_zero"}, 32'(m_trail_bad), 32'd0);
            check({e.name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(e.has_rsp));
            if (e.has_rsp) check({e.name, "_rsp_data"}, 32'(bus.rsp_data), 32'(e.rsp));
          end
          m_hi = 0;
        end else if (bus.rsp_valid !== 1'b0) begin
          rsp_spurious = 1'b1;
        end
        if (bus.MOSI !== 1'b0) m_trail_bad = 1'b1;
        m_hi++;
        prev_ss = 1'b1;
      end
    end
  end

  task automatic send(input logic [9:0] w, input exp_t e, input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = w;
    sb_q.push_back(e);
    for (int i = 0; i < 100; i++) begin
      if (bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({e.name, "_accepted"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check(name, sb_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss_n",      32'(bus.SS_n),      32'd1);
    check("rst_mosi",      32'(bus.MOSI),      32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus.rsp_data),  32'h00);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Write address / read address: short frames, no response.
    send(10'h0A5, mk("wr_addr", 13, 11'b00010100101, 1'b0, 8'h00), 1'b0);
    @(negedge clk);
    check("wr_addr_busy",  32'(bus.busy),      32'd1);
    check("wr_addr_ready", 32'(bus.cmd_ready), 32'd0);
    send(10'h23C, mk("rd_addr", 13, 11'b11000111100, 1'b0, 8'h00), 1'b0);

    // Read data: MISO 1,1,0,0,1,0,1,0 in the window, 1 outside it.
    miso_pat  = 8'hCA;
    miso_idle = 1'b1;
    send(10'h300, mk("rd_data", 23, 11'b11100000000, 1'b1, 8'hCA), 1'b0);
    drain("rd_data_drain");
    check("rsp_data_hold", 32'(bus.rsp_data), 32'hCA);

    // Busy rejection: valid stays high while the word changes mid-frame.
    miso_idle = 1'b0;
    send(10'h15A, mk("busy_first", 13, 11'b00101011010, 1'b0, 8'h00), 1'b1);
    bus.cmd_word = 10'h2C3;
    repeat (3) @(negedge clk);
    check("busy_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("busy_high",          32'(bus.busy),      32'd1);
    send(10'h2C3, mk("busy_second", 13, 11'b11011000011, 1'b0, 8'h00), 1'b0);

    // Back-to-back: write data then read data with MISO held low.
    miso_pat  = 8'h00;
    miso_idle = 1'b0;
    send(10'h1FF, mk("b2b_wr_data", 13, 11'b00111111111, 1'b0, 8'h00), 1'b0);
    send(10'h3FF, mk("b2b_rd_data", 23, 11'b11111111111, 1'b1, 8'h00), 1'b0);
    drain("b2b_drain");

    // Reset mid-frame at cnt=5 of a read-data command.
    miso_pat  = 8'hFF;
    miso_idle = 1'b1;
    send(10'h300, mk("rst_abort", 6, 11'b11100000000, 1'b0, 8'h00), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_ss_n",      32'(bus.SS_n),      32'd1);
    check("midrst_mosi",      32'(bus.MOSI),      32'd0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("midrst_rsp_data",  32'(bus.rsp_data),  32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("midrst_release_ss_n",      32'(bus.SS_n),      32'd1);
    drain("rst_drain");
    repeat (5) @(negedge clk);

    check("no_spurious_rsp_valid", 32'(rsp_spurious), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

Single-clock SPI master driving the team's SPI slave from the host side of the SPI wrapper. Accepts a 10-bit command word over a valid/ready handshake and serialises it MSB-first on MOSI inside an SS_n-low frame. For read-data commands it extends the frame, captures 8 bits from MISO and returns them on a response pulse. Frame lengths match the slave's checked timing: 13 cycles normally, 23 cycles for read-data.

## Interface
- FRAME_SHORT, 13: SS_n-low cycles for commands 00/01/10.
- FRAME_LONG, 23: SS_n-low cycles for command 11 (read data).
- MISO_START, 13: frame cycle index of the first MISO sample; the last sample is at MISO_START+7, and this must be ≤ FRAME_LONG-1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command word present.
- cmd_word  in  10  [9:8] is the opcode (00 wr addr, 01 wr data, 10 rd addr, 11 rd data); [7:0] is the payload.
- cmd_ready  out  1  high only in IDLE with rst_n high.
- MISO  in  1  serial data from the slave.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave.
- rsp_valid  out  1  one-cycle pulse; read data is available.
- rsp_data  out  8  captured read byte; holds its value until the next capture.
- busy  out  1  high from acceptance until the end of the GAP state.

## Operation
- States: IDLE, CMD, SHIFT, HOLD, READ, GAP.
- IDLE: SS_n=1, MOSI=0. A command is accepted when cmd_valid && cmd_ready. On acceptance, latch cmd_word, set is_rd = (cmd_word[9:8]==2'b11), set cnt=0, go to CMD.
- CMD (frame cycle 0): SS_n=0; MOSI=cmd_word[9], the state-select bit consumed by the slave's CHK_CMD.
- SHIFT (frame cycles 1..10): MOSI=cmd_word[10-k] at cycle k, so bit 9 goes out first and bit 0 last.
- HOLD: SS_n=0, MOSI=0. Hold until cnt = FRAME_SHORT-1 when !is_rd, then go to GAP. When is_rd, enter READ at cnt = MISO_START-1.
- READ: sample MISO at cnt = MISO_START..MISO_START+7, shifting into a byte register MSB-first. Stay with SS_n=0 until cnt = FRAME_LONG-1, then go to GAP.
- GAP: SS_n=1 for exactly one cycle; MOSI=0; return to IDLE. rsp_valid pulses in this cycle when is_rd, with rsp_data = the captured byte.
- cnt is a 5-bit frame counter that increments every non-IDLE, non-GAP cycle. It never wraps: the maximum value is 22.
- Commands presented while busy are ignored (cmd_ready=0) and are not queued.
- MISO is ignored outside the READ sample window.

## Timing
- Reset values, all registered and effective at the first clk edge with rst_n=0: SS_n=1, MOSI=0, rsp_valid=0, rsp_data=8'h00, busy=0, state=IDLE.
- cmd_ready=0 while rst_n=0.
- Reset mid-frame: SS_n rises at the next edge; cnt, the latched command and the partial byte are discarded; rsp_valid is not asserted.
- Acceptance at edge E: SS_n falls at E+1.
- Short frame: SS_n is low for cycles E+1..E+13 and high at E+14 (GAP). cmd_ready returns at E+15. The next frame can start with SS_n falling at E+16, i.e. at least one IDLE-high cycle after GAP.
- Long frame: SS_n is low for E+1..E+23; rsp_valid is at E+24.
- Back-to-back: the minimum command period is 15 cycles for a short frame and 25 for a long one.
- cmd_valid asserted in the same cycle as the GAP exit is not accepted until cmd_ready is high.

## Structure
- shared_pkg gains:
  - master_state_e {M_IDLE, M_CMD, M_SHIFT, M_HOLD, M_READ, M_GAP};
  - opcode constants CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA;
  - default frame lengths 13 and 23.
- One sub-module, spi_master_shifter: a 10-bit parallel-load/serial-out register plus an 8-bit serial-in register, with load/shift/capture enables driven by the FSM.
- The FSM and counter stay in spi_master.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-frame (cnt=5) -> SS_n=1 and MOSI=0 at the next edge; no rsp_valid pulse; cmd_ready=1 one cycle after release.
- Write address: cmd_word=10'h0A5 -> SS_n low for exactly 13 cycles. MOSI sequence: cycle 0 = 0, then bits 0,0,1,0,1,0,0,1,0,1. rsp_valid never asserted.
- Read address: cmd_word=10'h23C -> SS_n low for 13 cycles. Cycle 0 MOSI=1, then bits 1,0,0,0,1,1,1,1,0,0. No rsp_valid.
- Read data: cmd_word=10'h300, with the bench driving MISO bits 1,1,0,0,1,0,1,0 at cycles 13..20 -> SS_n low for 23 cycles; rsp_valid pulse at E+24 with rsp_data=8'hCA.
- Busy rejection: cmd_valid held high with a second word during a frame -> cmd_ready=0; the second word is accepted only after GAP, with SS_n high for at least 2 cycles between frames.
- Back-to-back mix: write data 10'h1FF, then read data 10'h3FF with MISO held at 0 -> frames are 13 and 23 cycles long; rsp_data=8'h00; the gap between frames is ≥ 2 cycles.
